// File: rtl/ipif_bus_master.sv
// Single-outstanding register-access initiator for IPIF-style slaves: drives a one-hot
// CE bus cycle, waits for the matching ack (bounded by TIMEOUT), and returns status.
module ipif_bus_master #(
    parameter int unsigned NUM_REGS = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                Bus2IP_Clk,
    input  logic                Bus2IP_Reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [7:0]          cmd_reg,
    input  logic [31:0]         cmd_data,
    input  logic [3:0]          cmd_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_data,
    output logic                rsp_error,
    output logic [31:0]         Bus2IP_Data,
    output logic [3:0]          Bus2IP_BE,
    output logic [NUM_REGS-1:0] Bus2IP_RdCE,
    output logic [NUM_REGS-1:0] Bus2IP_WrCE,
    input  logic [31:0]         IP2Bus_Data,
    input  logic                IP2Bus_RdAck,
    input  logic                IP2Bus_WrAck,
    input  logic                IP2Bus_Error
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                wr;
    logic                reg_ok;
    logic                ack;
    logic [NUM_REGS-1:0] ce_sel;

    // Register 0 maps to the CE MSB.
    always_comb begin
        reg_ok = ({24'd0, cmd_reg} < NUM_REGS);
        ce_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if ({24'd0, cmd_reg} == NUM_REGS - 1 - i) begin
                ce_sel[i] = 1'b1;
            end
        end
    end

    assign ack       = wr ? IP2Bus_WrAck : IP2Bus_RdAck;
    assign cmd_ready = (state == IDLE) && !Bus2IP_Reset;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wr          <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            Bus2IP_Data <= '0;
            Bus2IP_BE   <= '0;
            Bus2IP_RdCE <= '0;
            Bus2IP_WrCE <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (reg_ok) begin
                            wr          <= cmd_write;
                            Bus2IP_Data <= cmd_write ? cmd_data : '0;
                            Bus2IP_BE   <= cmd_be;
                            if (cmd_write) begin
                                Bus2IP_WrCE <= ce_sel;
                            end else begin
                                Bus2IP_RdCE <= ce_sel;
                            end
                            cnt   <= '0;
                            state <= ACCESS;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final allowed cycle takes priority over the timeout.
                    if (ack) begin
                        Bus2IP_RdCE <= '0;
                        Bus2IP_WrCE <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_error   <= IP2Bus_Error;
                        rsp_data    <= (!wr && !IP2Bus_Error) ? IP2Bus_Data : '0;
                        state       <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        Bus2IP_RdCE <= '0;
                        Bus2IP_WrCE <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_error   <= 1'b1;
                        rsp_data    <= '0;
                        state       <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipif_bus_master.sv
// Randomized bench for ipif_bus_master: a transaction-level model predicts CE duration,
// response status and data from the command and the slave's planned ack behaviour.
module tb_ipif_bus_master;

    localparam int unsigned NUM_REGS = 2;
    localparam int unsigned TIMEOUT  = 16;

    logic                clk;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [7:0]          cmd_reg;
    logic [31:0]         cmd_data;
    logic [3:0]          cmd_be;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_data;
    logic                rsp_error;
    logic [31:0]         bus_data;
    logic [3:0]          bus_be;
    logic [NUM_REGS-1:0] rd_ce;
    logic [NUM_REGS-1:0] wr_ce;
    logic [31:0]         ip_data;
    logic                rd_ack;
    logic                wr_ack;
    logic                ip_error;

    int checks   = 0;
    int failures = 0;

    ipif_bus_master #(.NUM_REGS(NUM_REGS), .TIMEOUT(TIMEOUT)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_reg      (cmd_reg),
        .cmd_data     (cmd_data),
        .cmd_be       (cmd_be),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .Bus2IP_Data  (bus_data),
        .Bus2IP_BE    (bus_be),
        .Bus2IP_RdCE  (rd_ce),
        .Bus2IP_WrCE  (wr_ce),
        .IP2Bus_Data  (ip_data),
        .IP2Bus_RdAck (rd_ack),
        .IP2Bus_WrAck (wr_ack),
        .IP2Bus_Error (ip_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts and ends at a negedge. d = CE cycle in which the slave acks (>TIMEOUT: never).
    task automatic run_txn(input logic w, input int unsigned r, input logic [31:0] wd,
                           input logic [3:0] be, input int unsigned d, input logic serr,
                           input logic [31:0] rd, input int unsigned bp);
        logic                bad;
        logic                hit;
        int unsigned         len;
        logic [NUM_REGS-1:0] mask;
        logic [2*NUM_REGS-1:0] exp_ce;
        logic                exp_err;
        logic [31:0]         exp_data;

        bad      = (r >= NUM_REGS);
        hit      = !bad && (d <= TIMEOUT);
        len      = bad ? 0 : (hit ? d : TIMEOUT);
        mask     = '0;
        if (!bad) mask[NUM_REGS-1-r] = 1'b1;
        exp_ce   = w ? {{NUM_REGS{1'b0}}, mask} : {mask, {NUM_REGS{1'b0}}};
        exp_err  = bad || !hit || serr;
        exp_data = (!w && hit && !serr) ? rd : 32'd0;

        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_reg   = 8'(r);
        cmd_data  = wd;
        cmd_be    = be;
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;

        for (int unsigned n = 1; n <= len; n++) begin
            @(negedge clk);
            check("ce_active", {rd_ce, wr_ce}, exp_ce);
            check("cmd_ready_busy", cmd_ready, 1'b0);
            if (n == 1) begin
                check("bus_data", bus_data, w ? wd : 32'd0);
                check("bus_be", bus_be, be);
            end
            ip_error = serr;
            ip_data  = (n == d) ? rd : $urandom;
            if (w) begin
                wr_ack = (n == d);
                rd_ack = 1'($urandom_range(0, 1));
            end else begin
                rd_ack = (n == d);
                wr_ack = 1'($urandom_range(0, 1));
            end
        end

        @(negedge clk);
        rd_ack   = 1'($urandom_range(0, 1));
        wr_ack   = 1'($urandom_range(0, 1));
        ip_error = 1'($urandom_range(0, 1));
        ip_data  = $urandom;
        check("ce_done", {rd_ce, wr_ce}, '0);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_error", rsp_error, exp_err);
        check("rsp_data", rsp_data, exp_data);
        check("cmd_ready_resp", cmd_ready, 1'b0);

        for (int unsigned k = 0; k < bp; k++) begin
            @(negedge clk);
            rd_ack = 1'($urandom_range(0, 1));
            wr_ack = 1'($urandom_range(0, 1));
            ip_data = $urandom;
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_data", rsp_data, exp_data);
            check("bp_error", rsp_error, exp_err);
            check("bp_cmd_ready", cmd_ready, 1'b0);
            check("bp_ce", {rd_ce, wr_ce}, '0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        check("post_valid", rsp_valid, 1'b0);
        check("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic reset_mid_access();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_reg   = 8'd0;
        cmd_be    = 4'hc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int unsigned n = 1; n <= 3; n++) begin
            @(negedge clk);
            check("rst_ce_before", {rd_ce, wr_ce}, 4'b1000);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ce", {rd_ce, wr_ce}, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cmd_ready_held", cmd_ready, 1'b0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_error", rsp_error, 1'b0);
        check("rst_bus_data", bus_data, 32'd0);
        check("rst_bus_be", bus_be, 4'd0);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready_after", cmd_ready, 1'b1);
        @(negedge clk);
        check("rst_no_rsp", rsp_valid, 1'b0);
        check("rst_ce_idle", {rd_ce, wr_ce}, '0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_reg   = '0;
        cmd_data  = '0;
        cmd_be    = '0;
        rsp_ready = 1'b0;
        ip_data   = '0;
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        ip_error  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_ce", {rd_ce, wr_ce}, '0);
        check("reset_bus_data", bus_data, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        #1;

        run_txn(1'b1, 0, 32'd7, 4'hf, 2, 1'b0, 32'd0, 0);
        run_txn(1'b0, 1, 32'd0, 4'hf, 1, 1'b0, 32'd56, 0);
        run_txn(1'b0, 0, 32'd0, 4'h3, TIMEOUT + 5, 1'b0, 32'd99, 2);
        run_txn(1'b1, 5, 32'h1234, 4'hf, 1, 1'b0, 32'd0, 0);
        run_txn(1'b0, 1, 32'd0, 4'hf, 3, 1'b1, 32'hdead, 0);
        run_txn(1'b0, 1, 32'd0, 4'h1, 4, 1'b0, 32'h0bad_cafe, 5);
        run_txn(1'b0, 0, 32'd0, 4'hf, TIMEOUT, 1'b0, 32'h5a5a_a5a5, 0);
        run_txn(1'b1, 1, 32'd9, 4'h8, TIMEOUT, 1'b1, 32'd0, 1);
        reset_mid_access();
        run_txn(1'b1, 1, 32'h00c0_ffee, 4'hf, 1, 1'b0, 32'd0, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom,
                    4'($urandom), $urandom_range(1, TIMEOUT + 3),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
